matrix_storage_loader: RTL and testbench

- Synthesizable loader that moves a stream of ELEM_W-bit elements into one of NUM_CH row-addressed matrix storages (weight/input/label class).
- Packs ELEMS_PER_ROW elements into one row word and issues a single-cycle write with layer and row index; auto-increments the row and wraps to the next layer.
- Sits between the host/DMA feed and the storage write interfaces. Generalises the fixed 3x16-bit, per-storage, externally-indexed write path.

---
 rtl/matrix_loader_pkg.sv | 19 +
 rtl/matrix_storage_loader_row_packer.sv | 51 +++++
 rtl/matrix_storage_loader.sv | 198 +++++++++++++++++++
 tb/tb_matrix_storage_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_loader_pkg.sv
// Shared types, default widths and helpers for the matrix storage loader.
package matrix_loader_pkg;

    localparam int ELEM_W_DEF = 16;
    localparam int IDX_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    // Select width that stays at least one bit wide for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_storage_loader_row_packer.sv
// Packs a stream of elements into one row word, first element in the MS slice.
module row_packer
    import matrix_loader_pkg::*;
#(
    parameter int ELEM_W        = ELEM_W_DEF,
    parameter int ELEMS_PER_ROW = 3
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic                              push,
    input  logic [ELEM_W-1:0]                 push_data,
    input  logic                              take,
    output logic                              row_last,
    output logic                              row_full,
    output logic [ELEM_W*ELEMS_PER_ROW-1:0]   row_data
);

    localparam int ROW_W = ELEM_W * ELEMS_PER_ROW;
    localparam int CNT_W = clog2_min1(ELEMS_PER_ROW + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [ROW_W-1:0] shift_q, shift_d;

    assign row_last = (count_q == CNT_W'(ELEMS_PER_ROW - 1));
    assign row_full = (count_q == CNT_W'(ELEMS_PER_ROW));
    assign row_data = shift_q;

    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        if (take) begin
            count_d = '0;
            shift_d = '0;
        end else if (push && !row_full) begin
            count_d = count_q + 1'b1;
            // Shifting left walks earlier elements toward the MS end.
            shift_d = (shift_q << ELEM_W) | ROW_W'(push_data);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
            shift_q <= '0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/matrix_storage_loader.sv
// Streams elements into row-addressed matrix storages, one packed row per write strobe.
// Optional running XOR of written rows is enabled by defining LOADER_CHECKSUM_EN.
module matrix_storage_loader
    import matrix_loader_pkg::*;
#(
    parameter int ELEM_W         = ELEM_W_DEF,
    parameter int ELEMS_PER_ROW  = 3,
    parameter int NUM_CH         = 3,
    parameter int IDX_W          = IDX_W_DEF,
    parameter int ROWS_PER_LAYER = 16
) (
    input  logic                               clk_clk,
    input  logic                               reset_reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [clog2_min1(NUM_CH)-1:0]      cmd_channel,
    input  logic [IDX_W-1:0]                   cmd_layer,
    input  logic [IDX_W-1:0]                   cmd_row,
    input  logic [IDX_W-1:0]                   cmd_row_count,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ELEM_W-1:0]                  in_data,
    output logic [NUM_CH-1:0]                  wr_is_write,
    output logic [ELEM_W*ELEMS_PER_ROW-1:0]    wr_data,
    output logic [IDX_W-1:0]                   wr_layer_index,
    output logic [IDX_W-1:0]                   wr_row_index,
    output logic                               busy,
    output logic                               done,
    output logic                               cmd_error,
    output logic [ELEM_W*ELEMS_PER_ROW-1:0]    checksum
);

    localparam int ROW_W = ELEM_W * ELEMS_PER_ROW;
    localparam int CH_W  = clog2_min1(NUM_CH);

    loader_state_e    state_q, state_d;
    logic [CH_W-1:0]  channel_q, channel_d;
    logic [IDX_W-1:0] layer_q, layer_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] remaining_q, remaining_d;
    logic [ROW_W-1:0] wr_data_q, wr_data_d;
    logic [IDX_W-1:0] wr_layer_q, wr_layer_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic             cmd_error_q, cmd_error_d;

    logic             cmd_accept;
    logic             cmd_bad;
    logic             elem_accept;
    logic             write_en;
    logic             row_last;
    logic             row_full;
    logic [ROW_W-1:0] packed_row;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign in_ready    = (state_q == ST_PACK);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign write_en    = (state_q == ST_WRITE);
    assign cmd_error   = cmd_error_q;
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign elem_accept = in_valid && in_ready;
    assign cmd_bad     = (int'(cmd_channel) >= NUM_CH)
                      || (cmd_row >= IDX_W'(ROWS_PER_LAYER));

    row_packer #(
        .ELEM_W        (ELEM_W),
        .ELEMS_PER_ROW (ELEMS_PER_ROW)
    ) u_row_packer (
        .clk       (clk_clk),
        .srst      (reset_reset),
        .push      (elem_accept),
        .push_data (in_data),
        .take      (write_en && row_full),
        .row_last  (row_last),
        .row_full  (row_full),
        .row_data  (packed_row)
    );

    always_comb begin
        state_d     = state_q;
        channel_d   = channel_q;
        layer_d     = layer_q;
        row_d       = row_q;
        remaining_d = remaining_q;
        cmd_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (cmd_bad) begin
                        cmd_error_d = 1'b1;
                    end else if (cmd_row_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        channel_d   = cmd_channel;
                        layer_d     = cmd_layer;
                        row_d       = cmd_row;
                        remaining_d = cmd_row_count;
                        state_d     = ST_PACK;
                    end
                end
            end
            ST_PACK: begin
                if (elem_accept && row_last) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                remaining_d = remaining_q - 1'b1;
                // Row walk rolls into the next layer; layer wraps silently.
                if (row_q == IDX_W'(ROWS_PER_LAYER - 1)) begin
                    row_d   = '0;
                    layer_d = layer_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
                state_d = (remaining_q == IDX_W'(1)) ? ST_DONE : ST_PACK;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-side fields are live during the strobe and held afterwards.
    always_comb begin
        wr_data_d  = wr_data_q;
        wr_layer_d = wr_layer_q;
        wr_row_d   = wr_row_q;
        if (write_en) begin
            wr_data_d  = packed_row;
            wr_layer_d = layer_q;
            wr_row_d   = row_q;
        end
    end

    assign wr_data        = wr_data_d;
    assign wr_layer_index = wr_layer_d;
    assign wr_row_index   = wr_row_d;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_strobe
        localparam logic [CH_W-1:0] CH_ID = CH_W'(gi);
        assign wr_is_write[gi] = write_en && (channel_q == CH_ID);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            channel_q   <= '0;
            layer_q     <= '0;
            row_q       <= '0;
            remaining_q <= '0;
            wr_data_q   <= '0;
            wr_layer_q  <= '0;
            wr_row_q    <= '0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            channel_q   <= channel_d;
            layer_q     <= layer_d;
            row_q       <= row_d;
            remaining_q <= remaining_d;
            wr_data_q   <= wr_data_d;
            wr_layer_q  <= wr_layer_d;
            wr_row_q    <= wr_row_d;
            cmd_error_q <= cmd_error_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [ROW_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (cmd_accept) begin
            checksum_d = '0;
        end else if (write_en) begin
            checksum_d = checksum_q ^ wr_data_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_storage_loader.sv
// Directed bench for matrix_storage_loader with a queue-based write model and per-cycle strobe checker.
module tb_matrix_storage_loader;

    localparam int EW  = 16;
    localparam int EPR = 3;
    localparam int NCH = 3;
    localparam int IW  = 32;
    localparam int RPL = 16;
    localparam int RW  = EW * EPR;

    logic            clk_clk = 1'b0;
    logic            reset_reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_channel;
    logic [IW-1:0]   cmd_layer;
    logic [IW-1:0]   cmd_row;
    logic [IW-1:0]   cmd_row_count;
    logic            in_valid;
    logic            in_ready;
    logic [EW-1:0]   in_data;
    logic [NCH-1:0]  wr_is_write;
    logic [RW-1:0]   wr_data;
    logic [IW-1:0]   wr_layer_index;
    logic [IW-1:0]   wr_row_index;
    logic            busy;
    logic            done;
    logic            cmd_error;
    logic [RW-1:0]   checksum;

    always #5 clk_clk = ~clk_clk;

    matrix_storage_loader #(
        .ELEM_W         (EW),
        .ELEMS_PER_ROW  (EPR),
        .NUM_CH         (NCH),
        .IDX_W          (IW),
        .ROWS_PER_LAYER (RPL)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_channel    (cmd_channel),
        .cmd_layer      (cmd_layer),
        .cmd_row        (cmd_row),
        .cmd_row_count  (cmd_row_count),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .wr_is_write    (wr_is_write),
        .wr_data        (wr_data),
        .wr_layer_index (wr_layer_index),
        .wr_row_index   (wr_row_index),
        .busy           (busy),
        .done           (done),
        .cmd_error      (cmd_error),
        .checksum       (checksum)
    );

    typedef struct packed {
        logic [NCH-1:0] strobe;
        logic [RW-1:0]  data;
        logic [IW-1:0]  layer;
        logic [IW-1:0]  row;
    } wr_t;

    wr_t            exp_q[$];
    logic [EW-1:0]  elems[$];
    logic [RW-1:0]  exp_csum;
    int             checks = 0;
    int             errors = 0;
    int             done_seen = 0;
    int             err_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected writes of a command: row k goes to row (row0+k) mod RPL, layer advanced by the carry.
    task automatic model_cmd(input int ch, input logic [IW-1:0] layer, input int row, input int count);
        exp_csum = '0;
        for (int r = 0; r < count; r++) begin
            wr_t w;
            w.strobe = NCH'(1) << ch;
            w.data   = '0;
            for (int k = 0; k < EPR; k++) begin
                w.data = (w.data << EW) | RW'(elems[r * EPR + k]);
            end
            w.layer = layer + IW'((row + r) / RPL);
            w.row   = IW'((row + r) % RPL);
            exp_q.push_back(w);
            exp_csum = exp_csum ^ w.data;
        end
    endtask

    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (done) done_seen++;
            if (cmd_error) err_seen++;
            if (wr_is_write != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 64'(wr_is_write), 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("model_strobe", 64'(wr_is_write), 64'(e.strobe));
                    check("model_data", 64'(wr_data), 64'(e.data));
                    check("model_layer", 64'(wr_layer_index), 64'(e.layer));
                    check("model_row", 64'(wr_row_index), 64'(e.row));
                    $display("write ch_mask=%b layer=%0d row=%0d data=0x%012h", wr_is_write,
                             wr_layer_index, wr_row_index, wr_data);
                end
            end
        end
    end

    task automatic issue_cmd(input int ch, input logic [IW-1:0] layer, input logic [IW-1:0] row,
                             input logic [IW-1:0] count);
        int n;
        @(posedge clk_clk); #1;
        cmd_valid     = 1'b1;
        cmd_channel   = 2'(ch);
        cmd_layer     = layer;
        cmd_row       = row;
        cmd_row_count = count;
        n = 0;
        forever begin
            @(negedge clk_clk);
            if (cmd_ready) break;
            n++;
            if (n > 50) begin
                check("cmd_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk_clk); #1;
        cmd_valid = 1'b0;
        $display("cmd ch=%0d layer=%0d row=%0d count=%0d", ch, layer, row, count);
    endtask

    task automatic send_elem(input logic [EW-1:0] v, input int gaps);
        int n;
        in_valid = 1'b0;
        repeat (gaps) begin
            @(posedge clk_clk); #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        forever begin
            @(negedge clk_clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(negedge clk_clk);
            if (done) break;
            n++;
            if (n > 100) begin
                check("done_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset   = 1'b1;
        cmd_valid     = 1'b0;
        cmd_channel   = '0;
        cmd_layer     = '0;
        cmd_row       = '0;
        cmd_row_count = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        repeat (3) @(posedge clk_clk);
        #1 reset_reset = 1'b0;

        @(negedge clk_clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cmd_error", 64'(cmd_error), 64'd0);
        check("rst_strobe", 64'(wr_is_write), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);

        // Test 1: two rows on channel 1, no gaps.
        elems = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        model_cmd(1, 32'd2, 0, 2);
        issue_cmd(1, 32'd2, 32'd0, 32'd2);
        for (int i = 0; i < 3; i++) send_elem(elems[i], 0);
        @(negedge clk_clk);
        check("t1_strobe0", 64'(wr_is_write), 64'h2);
        check("t1_data0", 64'(wr_data), 64'h0001_0002_0003);
        check("t1_row0", 64'(wr_row_index), 64'd0);
        for (int i = 3; i < 6; i++) send_elem(elems[i], 0);
        @(negedge clk_clk);
        check("t1_strobe1", 64'(wr_is_write), 64'h2);
        check("t1_data1", 64'(wr_data), 64'h0004_0005_0006);
        check("t1_row1", 64'(wr_row_index), 64'd1);
        check("t1_layer1", 64'(wr_layer_index), 64'd2);
        @(negedge clk_clk);
        check("t1_done", 64'(done), 64'd1);
        check("t1_hold_data", 64'(wr_data), 64'h0004_0005_0006);
`ifdef LOADER_CHECKSUM_EN
        check("t1_checksum", 64'(checksum), 64'h0005_0007_0005);
        check("t1_checksum_model", 64'(checksum), 64'(exp_csum));
`endif

        // Test 2: row 15 rolls into the next layer.
        elems = '{16'hA001, 16'hA002, 16'hA003, 16'hB001, 16'hB002, 16'hB003};
        model_cmd(0, 32'd5, 15, 2);
        issue_cmd(0, 32'd5, 32'd15, 32'd2);
        for (int i = 0; i < 3; i++) send_elem(elems[i], 0);
        @(negedge clk_clk);
        check("t2_strobe0", 64'(wr_is_write), 64'h1);
        check("t2_layer0", 64'(wr_layer_index), 64'd5);
        check("t2_row0", 64'(wr_row_index), 64'd15);
        for (int i = 3; i < 6; i++) send_elem(elems[i], 0);
        @(negedge clk_clk);
        check("t2_layer1", 64'(wr_layer_index), 64'd6);
        check("t2_row1", 64'(wr_row_index), 64'd0);
        wait_done();

        // Test 3: rejected commands (bad channel, bad row).
        issue_cmd(3, 32'd0, 32'd0, 32'd1);
        @(negedge clk_clk);
        check("t3_err_pulse", 64'(cmd_error), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        @(negedge clk_clk);
        check("t3_err_clear", 64'(cmd_error), 64'd0);
        issue_cmd(0, 32'd0, 32'd16, 32'd1);
        @(negedge clk_clk);
        check("t3_row_err", 64'(cmd_error), 64'd1);

        // Test 4: zero-row command completes without a strobe.
        issue_cmd(2, 32'd7, 32'd3, 32'd0);
        @(negedge clk_clk);
        check("t4_done", 64'(done), 64'd1);
        check("t4_busy", 64'(busy), 64'd1);
        @(negedge clk_clk);
        check("t4_done_clear", 64'(done), 64'd0);
        check("t4_idle", 64'(busy), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        check("t4_checksum_clear", 64'(checksum), 64'd0);
`endif

        // Test 5: random gaps, layer index wraps past all-ones.
        elems = {};
        for (int i = 0; i < 9; i++) elems.push_back(EW'($urandom));
        model_cmd(2, 32'hFFFF_FFFF, 14, 3);
        issue_cmd(2, 32'hFFFF_FFFF, 32'd14, 32'd3);
        for (int i = 0; i < 9; i++) send_elem(elems[i], $urandom_range(0, 3));
        wait_done();
`ifdef LOADER_CHECKSUM_EN
        check("t5_checksum_model", 64'(checksum), 64'(exp_csum));
`endif
        check("t5_queue_drained", 64'(exp_q.size()), 64'd0);

        // Test 6: reset mid-row abandons the command.
        elems = '{16'h1111, 16'h2222, 16'h3333};
        issue_cmd(1, 32'd9, 32'd3, 32'd1);
        send_elem(elems[0], 0);
        send_elem(elems[1], 0);
        reset_reset = 1'b1;
        in_valid    = 1'b1;
        in_data     = elems[2];
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        @(negedge clk_clk);
        check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd0);
        check("t6_wr_data", 64'(wr_data), 64'd0);
        check("t6_wr_layer", 64'(wr_layer_index), 64'd0);
        check("t6_wr_row", 64'(wr_row_index), 64'd0);
        repeat (10) @(negedge clk_clk);
        in_valid = 1'b0;
        check("t6_no_strobe", 64'(wr_is_write), 64'd0);

        check("total_done", 64'(done_seen), 64'd4);
        check("total_errors", 64'(err_seen), 64'd2);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
